// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart receiver
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchroniser resetting to the idle-high level
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the asynchronous input through the chain; reset to line-idle level
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 serial receiver with one-entry holding register
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin,
  input  logic       data_ready,
  output logic [7:0] byte_received,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(clocks_per_bit) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF     = CW'((clocks_per_bit - 1) / 2);
  localparam logic [CW-1:0] LAST     = CW'(clocks_per_bit - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic                 rx;
  state_t               state;
  logic [CW-1:0]        counter;
  logic [IW-1:0]        bit_index;
  logic [DATA_BITS-1:0] shift_reg;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (pin),
    .q    (rx)
  );

  // frame recovery FSM plus holding register and error pulse generation
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      bit_index     <= '0;
      shift_reg     <= '0;
      byte_received <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      // a consumer handshake drains the register unless a new byte lands below
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx) begin
            state   <= START;
            counter <= '0;
          end
        end

        START: begin
          if (counter == HALF) begin
            counter <= '0;
            if (!rx) begin
              state     <= DATA;
              bit_index <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        DATA: begin
          if (counter == LAST) begin
            counter   <= '0;
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
            if (bit_index == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        STOP: begin
          if (counter == LAST) begin
            counter <= '0;
            if (rx) begin
              state <= IDLE;
              if (!data_valid || data_ready) begin
                byte_received <= shift_reg;
                data_valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // a held-low line (break) must not look like a fresh start bit
          if (rx) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for the uart receiver
module tb_uart_receiver;

  localparam int CPB = 4;
  localparam int EV_BYTE = 0;
  localparam int EV_OVR  = 1;
  localparam int EV_FERR = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pin = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] byte_received;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  model_full = 1'b0;
  bit  ready_hold = 1'b0;
  logic pv = 1'b0;
  logic pr = 1'b0;

  uart_receiver #(.clocks_per_bit(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .pin          (pin),
    .data_ready   (data_ready),
    .byte_received(byte_received),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // expected outcome of a frame, decided from the 8N1 rules and the holding-register model
  task automatic expect_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.data = b;
    if (!stop) begin
      e.kind = EV_FERR;
    end else if (model_full) begin
      e.kind = EV_OVR;
    end else begin
      e.kind = EV_BYTE;
      model_full = !ready_hold;
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    pin = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    expect_frame(b, stop);
    send_bits(b, stop);
    if (!stop) hold(1'b0, 20);
    hold(1'b1, 2 * CPB + 4);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    @(posedge clock);
    #1;
    data_ready = 1'b0;
    model_full = 1'b0;
  endtask

  task automatic handle(input int kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_BYTE && e.kind == EV_BYTE) check("byte_received", data, e.data);
    end
  endtask

  // monitor: turns output activity into events and pops the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (framing_error && overrun) check("error_exclusive", 1, 0);
        if (data_valid && (!pv || pr)) handle(EV_BYTE, byte_received);
        if (overrun) handle(EV_OVR, 8'h00);
        if (framing_error) handle(EV_FERR, 8'h00);
      end
      pv = data_valid;
      pr = data_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    int         mode;

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", data_valid, 0);
    check("reset_byte", byte_received, 8'h00);
    check("reset_ferr", framing_error, 0);
    check("reset_ovr", overrun, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    hold(1'b1, 4);

    // single byte, consumer stalled
    send_frame(8'h55, 1'b1);
    check("single_valid", data_valid, 1);
    check("single_byte", byte_received, 8'h55);
    check("single_busy", busy, 0);
    drain();

    // two bytes, each drained after delivery
    send_frame(8'hA3, 1'b1);
    drain();
    check("drained_valid", data_valid, 0);
    send_frame(8'h0F, 1'b1);
    drain();

    // overrun
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check("overrun_valid", data_valid, 1);
    check("overrun_keep", byte_received, 8'h12);
    drain();

    // framing error with a break
    expect_frame(8'hFF, 1'b0);
    send_bits(8'hFF, 1'b0);
    hold(1'b0, 20);
    check("break_busy", busy, 1);
    check("break_valid", data_valid, 0);
    hold(1'b1, 2 * CPB + 4);
    check("break_idle", busy, 0);

    // one-clock glitch
    hold(1'b0, 1);
    hold(1'b1, 12);
    check("glitch_busy", busy, 0);
    check("glitch_valid", data_valid, 0);

    // reset during a frame, with an undrained byte pending
    send_frame(8'h77, 1'b1);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_valid", data_valid, 0);
    check("midreset_byte", byte_received, 8'h00);
    check("midreset_busy", busy, 0);
    check("midreset_ferr", framing_error, 0);
    check("midreset_ovr", overrun, 0);
    reset = 1'b0;
    model_full = 1'b0;
    hold(1'b1, 4);
    send_frame(8'h5A, 1'b1);
    check("after_reset_byte", byte_received, 8'h5A);
    drain();

    // randomized frames and consumer behaviour
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        data_ready = 1'b1;
        ready_hold = 1'b1;
        model_full = 1'b0;
      end else begin
        data_ready = 1'b0;
        ready_hold = 1'b0;
      end
      send_frame(b, stop);
      if (mode == 1) drain();
    end
    ready_hold = 1'b0;
    drain();

    hold(1'b1, 20);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
